// File: rtl/sst_hotkey_ctrl.sv
// ============================================================================
// Module   : sst_hotkey_ctrl
// Brief    : Multi-port joypad hotkey sniffer and save-state sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sst_hotkey_ctrl #(
  parameter int          NPORTS   = 2,
  parameter int          HOLD_IRQ = 4,
  parameter int          TMO_W    = 24,
  parameter logic [23:0] JOY_BASE = 24'hA10002
) (
  input  logic                  clk,
  input  logic                  map_rst_n,
  input  logic                  on,
  input  logic [23:0]           cpu_addr,
  input  logic [15:0]           cpu_data,
  input  logic                  as_n,
  input  logic                  oe_n,
  input  logic                  we_lo_n,
  input  logic [NPORTS-1:0]     port_en,
  input  logic [7:0]            key_save,
  input  logic [7:0]            key_load,
  input  logic [7:0]            key_menu,
  input  logic [TMO_W-1:0]      tmo_limit,
  output logic [8*NPORTS-1:0]   joy_val,
  output logic                  sst_act,
  output logic [1:0]            ss_state,
  output logic [1:0]            sst_cmd,
  output logic [1:0]            sst_port,
  output logic [7:0]            joy_keys,
  output logic                  tmo_err
);

  localparam int          HW        = $clog2(HOLD_IRQ + 1);
  localparam logic [HW-1:0] HOLD_TGT = HW'(HOLD_IRQ);
  localparam logic [HW-1:0] HOLD_MAX = '1;

  localparam logic [1:0] ST_INGAME = 2'd0;
  localparam logic [1:0] ST_BACKUP = 2'd1;
  localparam logic [1:0] ST_RECOVR = 2'd2;

  logic              irq_s, irq_q, irq_edge;
  logic              ack_s, ack_q, ack_edge;
  logic [NPORTS-1:0] rd_s, rd_q, rd_end;
  logic [NPORTS-1:0] wr_s, wr_q, wr_edge;
  logic              unused_data;

  assign irq_s       = !as_n && !oe_n    && (cpu_addr == 24'h000078);
  assign ack_s       = !as_n && !we_lo_n && (cpu_addr == 24'h000000);
  assign irq_edge    = irq_s && !irq_q;
  assign ack_edge    = ack_s && !ack_q;
  assign rd_end      = rd_q & ~rd_s;
  assign wr_edge     = wr_s & ~wr_q;
  assign unused_data = ^cpu_data[15:8];

  always_ff @(negedge clk) begin
    if (!map_rst_n) begin
      irq_q <= 1'b0;
      ack_q <= 1'b0;
      rd_q  <= '0;
      wr_q  <= '0;
    end else begin
      irq_q <= irq_s;
      ack_q <= ack_s;
      rd_q  <= rd_s;
      wr_q  <= wr_s;
    end
  end

  // Per-port sniffer: the pad is multiplexed by the select bit, so each
  // half of the key byte is latched once per frame from the matching phase.
  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    localparam logic [23:0] ADDR = JOY_BASE + 24'(2 * p);

    logic       sel;
    logic [7:0] dat_st;
    logic [7:0] joy;
    logic [1:0] mask;
    logic [1:0] mask_clr;

    assign rd_s[p]   = !as_n && !oe_n    && (cpu_addr == ADDR);
    assign wr_s[p]   = !as_n && !we_lo_n && (cpu_addr == ADDR);
    assign mask_clr  = irq_edge ? 2'b00 : mask;
    assign joy_val[8*p +: 8] = joy;

    always_ff @(negedge clk) begin
      if (!map_rst_n) begin
        sel    <= 1'b0;
        dat_st <= 8'h00;
        joy    <= 8'h00;
        mask   <= 2'b00;
      end else begin
        if (wr_edge[p]) sel <= cpu_data[6];
        if (rd_s[p])    dat_st <= ~cpu_data[7:0];
        mask <= mask_clr;
        if (rd_end[p] && !mask_clr[sel]) begin
          if (sel) joy[5:0] <= dat_st[5:0];
          else     joy[7:6] <= dat_st[5:4];
          mask <= mask_clr | (sel ? 2'b10 : 2'b01);
        end
      end
    end
  end

  logic       win_vld;
  logic [1:0] win_port;
  logic [1:0] win_cmd;
  logic [7:0] win_keys;

  // Later assignments win: ports scanned high to low, save checked last.
  always_comb begin
    win_vld  = 1'b0;
    win_port = 2'd0;
    win_cmd  = 2'd0;
    win_keys = 8'h00;
    for (int p = NPORTS - 1; p >= 0; p--) begin
      if (port_en[p]) begin
        if (key_menu != 8'h00 && joy_val[8*p +: 8] == key_menu) begin
          win_vld = 1'b1; win_port = 2'(p); win_cmd = 2'd3; win_keys = joy_val[8*p +: 8];
        end
        if (key_load != 8'h00 && joy_val[8*p +: 8] == key_load) begin
          win_vld = 1'b1; win_port = 2'(p); win_cmd = 2'd2; win_keys = joy_val[8*p +: 8];
        end
        if (key_save != 8'h00 && joy_val[8*p +: 8] == key_save) begin
          win_vld = 1'b1; win_port = 2'(p); win_cmd = 2'd1; win_keys = joy_val[8*p +: 8];
        end
      end
    end
  end

  logic [1:0]       state, state_nxt;
  logic [HW-1:0]    hold_cnt, hold_inc, hold_nxt;
  logic             prev_vld, lock;
  logic [1:0]       prev_port, prev_cmd;
  logic [TMO_W-1:0] tmo_cnt;
  logic             same_win, fire, tmo_hit;

  assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
  assign same_win = prev_vld && (prev_port == win_port) && (prev_cmd == win_cmd);
  assign hold_nxt = !win_vld ? '0 : (same_win ? hold_inc : HW'(1));
  assign fire     = irq_edge && win_vld && (hold_nxt == HOLD_TGT) && !lock;
  assign tmo_hit  = (tmo_limit != '0) && (tmo_cnt == tmo_limit - 1'b1);

  always_ff @(negedge clk) begin
    if (!map_rst_n) state <= ST_INGAME;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!on) begin
      state_nxt = ST_INGAME;
    end else begin
      case (state)
        ST_INGAME: if (fire) state_nxt = ST_BACKUP;
        ST_BACKUP: begin
          if (ack_edge)     state_nxt = ST_RECOVR;
          else if (tmo_hit) state_nxt = ST_INGAME;
        end
        ST_RECOVR: if (irq_edge) state_nxt = ST_INGAME;
        default:   state_nxt = ST_INGAME;
      endcase
    end
  end

  always_comb begin
    sst_act  = (state != ST_INGAME);
    ss_state = state;
  end

  always_ff @(negedge clk) begin
    if (!map_rst_n) begin
      hold_cnt  <= '0;
      prev_vld  <= 1'b0;
      prev_port <= 2'd0;
      prev_cmd  <= 2'd0;
      lock      <= 1'b0;
      tmo_cnt   <= '0;
      sst_cmd   <= 2'd0;
      sst_port  <= 2'd0;
      joy_keys  <= 8'h00;
      tmo_err   <= 1'b0;
    end else if (!on) begin
      hold_cnt <= '0;
      lock     <= 1'b0;
    end else begin
      case (state)
        ST_INGAME: if (irq_edge) begin
          hold_cnt  <= hold_nxt;
          prev_vld  <= win_vld;
          prev_port <= win_port;
          prev_cmd  <= win_cmd;
          if (!win_vld) lock <= 1'b0;
          if (fire) begin
            sst_cmd  <= win_cmd;
            sst_port <= win_port;
            joy_keys <= win_keys;
            lock     <= 1'b1;
            tmo_err  <= 1'b0;
            tmo_cnt  <= '0;
          end
        end
        ST_BACKUP: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (!ack_edge && tmo_hit) tmo_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sst_hotkey_ctrl.sv
// ============================================================================
// Module   : tb_sst_hotkey_ctrl
// Brief    : Directed and randomized bench for sst_hotkey_ctrl with a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sst_hotkey_ctrl;

  localparam int          NP   = 2;
  localparam int          HOLD = 4;
  localparam int          TW   = 24;
  localparam logic [23:0] BASE = 24'hA10002;
  localparam int          HMAX = (1 << $clog2(HOLD + 1)) - 1;

  logic            clk = 1'b0;
  logic            map_rst_n = 1'b0;
  logic            on = 1'b1;
  logic [23:0]     cpu_addr = 24'h0;
  logic [15:0]     cpu_data = 16'h0;
  logic            as_n = 1'b1, oe_n = 1'b1, we_lo_n = 1'b1;
  logic [NP-1:0]   port_en = '1;
  logic [7:0]      key_save = 8'h41, key_load = 8'h42, key_menu = 8'h60;
  logic [TW-1:0]   tmo_limit = '0;
  logic [8*NP-1:0] joy_val;
  logic            sst_act, tmo_err;
  logic [1:0]      ss_state, sst_cmd, sst_port;
  logic [7:0]      joy_keys;

  sst_hotkey_ctrl #(.NPORTS(NP), .HOLD_IRQ(HOLD), .TMO_W(TW), .JOY_BASE(BASE)) dut (
    .clk(clk), .map_rst_n(map_rst_n), .on(on), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .as_n(as_n), .oe_n(oe_n), .we_lo_n(we_lo_n), .port_en(port_en),
    .key_save(key_save), .key_load(key_load), .key_menu(key_menu), .tmo_limit(tmo_limit),
    .joy_val(joy_val), .sst_act(sst_act), .ss_state(ss_state), .sst_cmd(sst_cmd),
    .sst_port(sst_port), .joy_keys(joy_keys), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0, bk_cycles = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: state as plain integers, updated on the active edge.
  int         m_st = 0, m_hold = 0, m_pp = 0, m_pc = 0;
  longint     m_tmo = 0;
  bit         m_pv = 0, m_lock = 0, m_err = 0;
  logic [1:0] m_cmd = 0, m_port = 0;
  logic [7:0] m_keys = 0;
  logic [7:0] m_joy [NP];
  logic [7:0] m_dat [NP];
  bit         m_sel [NP];
  bit [1:0]   m_mask[NP];
  bit         p_irq = 0, p_ack = 0;
  bit         p_rd[NP], p_wr[NP], c_rd[NP], c_wr[NP];
  bit         c_irq, c_ack, e_irq, e_ack, e_rd, e_wr, wv, s;
  int         wp, wc, nh;
  logic [7:0] wk;

  initial begin
    for (int p = 0; p < NP; p++) begin
      m_joy[p] = 0; m_dat[p] = 0; m_sel[p] = 0; m_mask[p] = 0; p_rd[p] = 0; p_wr[p] = 0;
    end
    forever begin
      @(negedge clk);
      c_irq = !as_n && !oe_n && cpu_addr == 24'h78;
      c_ack = !as_n && !we_lo_n && cpu_addr == 24'h0;
      for (int p = 0; p < NP; p++) begin
        c_rd[p] = !as_n && !oe_n && cpu_addr == BASE + 24'(2 * p);
        c_wr[p] = !as_n && !we_lo_n && cpu_addr == BASE + 24'(2 * p);
      end
      if (!map_rst_n) begin
        m_st = 0; m_hold = 0; m_pp = 0; m_pc = 0; m_tmo = 0; m_pv = 0; m_lock = 0;
        m_err = 0; m_cmd = 0; m_port = 0; m_keys = 0; p_irq = 0; p_ack = 0;
        for (int p = 0; p < NP; p++) begin
          m_joy[p] = 0; m_dat[p] = 0; m_sel[p] = 0; m_mask[p] = 0; p_rd[p] = 0; p_wr[p] = 0;
        end
      end else begin
        e_irq = c_irq && !p_irq;
        e_ack = c_ack && !p_ack;
        wv = 0; wp = 0; wc = 0; wk = 0;
        for (int p = 0; p < NP && !wv; p++) begin
          if (port_en[p]) begin
            if (key_save != 0 && m_joy[p] == key_save)      begin wv = 1; wp = p; wc = 1; end
            else if (key_load != 0 && m_joy[p] == key_load) begin wv = 1; wp = p; wc = 2; end
            else if (key_menu != 0 && m_joy[p] == key_menu) begin wv = 1; wp = p; wc = 3; end
            if (wv) wk = m_joy[p];
          end
        end
        if (!on) begin
          m_st = 0; m_hold = 0; m_lock = 0;
        end else if (m_st == 0) begin
          if (e_irq) begin
            if (!wv) nh = 0;
            else if (m_pv && wp == m_pp && wc == m_pc) nh = (m_hold >= HMAX) ? HMAX : m_hold + 1;
            else nh = 1;
            if (wv && nh == HOLD && !m_lock) begin
              m_st = 1; m_cmd = 2'(wc); m_port = 2'(wp); m_keys = wk;
              m_lock = 1; m_err = 0; m_tmo = 0;
            end
            if (!wv) m_lock = 0;
            m_hold = nh; m_pv = wv; m_pp = wp; m_pc = wc;
          end
        end else if (m_st == 1) begin
          if (e_ack) m_st = 2;
          else if (tmo_limit != 0 && m_tmo == longint'(tmo_limit) - 1) begin m_st = 0; m_err = 1; end
          m_tmo++;
        end else begin
          if (e_irq) m_st = 0;
        end
        for (int p = 0; p < NP; p++) begin
          s = m_sel[p];
          e_rd = !c_rd[p] && p_rd[p];
          e_wr = c_wr[p] && !p_wr[p];
          if (e_irq) m_mask[p] = 0;
          if (e_rd && !m_mask[p][s]) begin
            if (s) m_joy[p][5:0] = m_dat[p][5:0];
            else   m_joy[p][7:6] = m_dat[p][5:4];
            m_mask[p][s] = 1;
          end
          if (c_rd[p]) m_dat[p] = ~cpu_data[7:0];
          if (e_wr) m_sel[p] = cpu_data[6];
          p_rd[p] = c_rd[p]; p_wr[p] = c_wr[p];
        end
        p_irq = c_irq; p_ack = c_ack;
      end
    end
  end

  function automatic logic [8*NP-1:0] pack_joy();
    logic [8*NP-1:0] r;
    for (int p = 0; p < NP; p++) r[8*p +: 8] = m_joy[p];
    return r;
  endfunction

  always @(posedge clk) begin
    if (cmp_en) begin
      n_vec++;
      if (joy_val !== pack_joy() || ss_state !== 2'(m_st) || sst_act !== (m_st != 0) ||
          sst_cmd !== m_cmd || sst_port !== m_port || joy_keys !== m_keys || tmo_err !== m_err) begin
        n_bad++;
        $display("FAIL cycle t=%0t: dut joy=%h st=%0d act=%b cmd=%0d port=%0d keys=%h err=%b; want joy=%h st=%0d cmd=%0d port=%0d keys=%h err=%b",
                 $time, joy_val, ss_state, sst_act, sst_cmd, sst_port, joy_keys, tmo_err,
                 pack_joy(), m_st, m_cmd, m_port, m_keys, m_err);
      end
    end
  end

  always @(posedge clk) if (ss_state == 2'd1) bk_cycles++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic [23:0] a, input logic [15:0] d, input bit wr, input int len);
    @(posedge clk); #1;
    cpu_addr = a; cpu_data = d; as_n = 1'b0;
    if (wr) we_lo_n = 1'b0; else oe_n = 1'b0;
    repeat (len) begin @(posedge clk); #1; end
    as_n = 1'b1; oe_n = 1'b1; we_lo_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic irq(input int len);
    bus(24'h78, 16'($urandom), 1'b0, len);
  endtask

  task automatic frame(input int p, input logic [7:0] k);
    logic [23:0] a;
    logic [7:0]  lo, hi;
    a  = BASE + 24'(2 * p);
    lo = ~{2'b00, k[5:0]};
    hi = ~{2'b00, k[7:6], 4'h0};
    bus(a, 16'h0040, 1'b1, 1);
    bus(a, {8'hFF, lo}, 1'b0, 1);
    bus(a, 16'h0000, 1'b1, 1);
    bus(a, {8'hFF, hi}, 1'b0, 1);
  endtask

  task automatic rd_then_irq(input int p, input logic [15:0] d, input int l1, input int l2);
    @(posedge clk); #1;
    cpu_addr = BASE + 24'(2 * p); cpu_data = d; as_n = 1'b0; oe_n = 1'b0;
    repeat (l1) begin @(posedge clk); #1; end
    cpu_addr = 24'h78;
    repeat (l2) begin @(posedge clk); #1; end
    as_n = 1'b1; oe_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic hold_frames(input logic [7:0] k0, input logic [7:0] k1, input int n);
    repeat (n) begin
      frame(0, k0);
      frame(1, k1);
      irq(1);
    end
  endtask

  function automatic logic [7:0] pick_key();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return key_save;
      2:       return key_load;
      3:       return key_menu;
      default: return 8'($urandom);
    endcase
  endfunction

  logic [7:0] held[NP];
  int guard;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_state", ss_state, 0);
    chk("rst_joy", joy_val, 0);
    chk("rst_cmd", {sst_act, sst_cmd, sst_port, joy_keys, tmo_err}, 0);
    map_rst_n = 1'b1;

    // sniffer: START arrives through the select-low phase
    bus(BASE, 16'h0040, 1'b1, 1);
    bus(BASE, 16'h00DF, 1'b0, 1);
    chk("t1_joy_first", joy_val[7:0], 8'h20);
    chk("t1_model_first", m_joy[0], 8'h20);
    bus(BASE, 16'h0000, 1'b1, 1);
    bus(BASE, 16'h00EF, 1'b0, 2);
    chk("t1_joy_second", joy_val[7:0], 8'h60);
    irq(1);

    hold_frames(8'h60, 8'h00, 3);
    chk("t2_state", ss_state, 1);
    chk("t2_cmd", sst_cmd, 3);
    chk("t2_keys", joy_keys, 8'h60);
    chk("t2_model_keys", m_keys, 8'h60);
    chk("t2_port", sst_port, 0);

    bus(24'h0, 16'h1234, 1'b1, 1);
    chk("t3_recovr", ss_state, 2);
    irq(2);
    chk("t3_ingame", sst_act, 0);
    hold_frames(8'h60, 8'h00, 2);
    chk("t2_no_retrigger", ss_state, 0);

    hold_frames(8'h00, 8'h00, 1);
    tmo_limit = 24'd100;
    hold_frames(8'h60, 8'h00, 3);
    bk_cycles = 0;
    hold_frames(8'h60, 8'h00, 1);
    chk("t4_enter", ss_state, 1);
    for (guard = 0; guard < 300 && ss_state != 2'd0; guard++) begin @(posedge clk); #1; end
    chk("t4_tmo_cycles", bk_cycles, 100);
    chk("t4_tmo_err", tmo_err, 1);

    hold_frames(8'h00, 8'h00, 1);
    hold_frames(8'h60, 8'h00, 3);
    bk_cycles = 0;
    hold_frames(8'h60, 8'h00, 1);
    for (guard = 0; guard < 300 && bk_cycles < 100; guard++) begin @(posedge clk); #1; end
    cpu_addr = 24'h0; as_n = 1'b0; we_lo_n = 1'b0;
    @(posedge clk); #1;
    chk("t4_ack_wins", ss_state, 2);
    chk("t4_ack_err", tmo_err, 0);
    as_n = 1'b1; we_lo_n = 1'b1;
    tmo_limit = '0;
    irq(1);

    hold_frames(8'h00, 8'h00, 1);
    hold_frames(8'h42, 8'h41, 4);
    chk("t5_port_lo", {sst_port, sst_cmd}, {2'd0, 2'd2});
    bus(24'h0, 16'h0, 1'b1, 1);
    irq(1);
    port_en = 2'b10;
    hold_frames(8'h00, 8'h00, 1);
    hold_frames(8'h42, 8'h41, 4);
    chk("t5_port_hi", {sst_port, sst_cmd, joy_keys}, {2'd1, 2'd1, 8'h41});
    bus(24'h0, 16'h0, 1'b1, 1);
    irq(1);

    port_en = 2'b01;
    hold_frames(8'h00, 8'h00, 1);
    hold_frames(8'h60, 8'h00, 2);
    hold_frames(8'h00, 8'h00, 1);
    hold_frames(8'h60, 8'h00, 3);
    chk("t6_release", ss_state, 0);
    hold_frames(8'h60, 8'h00, 1);
    chk("t6_after_release", ss_state, 1);
    on = 1'b0;
    @(posedge clk); #1;
    chk("t6_off_state", ss_state, 0);
    chk("t6_off_keep", sst_cmd, 3);
    on = 1'b1;
    hold_frames(8'h60, 8'h00, 4);
    chk("t6_retrig", ss_state, 1);
    map_rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_state", ss_state, 0);
    chk("t6_rst_out", {joy_val, sst_cmd, joy_keys}, 0);
    map_rst_n = 1'b1;
    port_en = '1;

    for (int p = 0; p < NP; p++) held[p] = pick_key();
    for (int it = 0; it < 700; it++) begin
      int r, p;
      r = $urandom_range(0, 99);
      p = $urandom_range(0, NP - 1);
      if (r < 45) begin
        if ($urandom_range(0, 4) == 0) held[p] = pick_key();
        frame(p, held[p]);
      end else if (r < 70) irq($urandom_range(1, 3));
      else if (r < 75) bus(24'h0, 16'($urandom), 1'b1, $urandom_range(1, 3));
      else if (r < 80) rd_then_irq(p, 16'($urandom), $urandom_range(1, 2), $urandom_range(1, 2));
      else if (r < 86) begin
        logic [23:0] a;
        case ($urandom_range(0, 3))
          0:       a = BASE + 24'(2 * p);
          1:       a = 24'h78;
          2:       a = 24'h0;
          default: a = 24'($urandom);
        endcase
        bus(a, 16'($urandom), 1'($urandom), $urandom_range(1, 3));
      end else if (r < 90) repeat ($urandom_range(1, 5)) begin @(posedge clk); #1; end
      else if (r < 93) on = ($urandom_range(0, 3) != 0);
      else if (r < 95) tmo_limit = ($urandom_range(0, 2) == 0) ? TW'($urandom_range(0, 2))
                                                               : TW'($urandom_range(3, 40));
      else if (r < 97) port_en = NP'($urandom);
      else if (r < 98) begin
        map_rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        map_rst_n = 1'b1;
      end else begin
        case ($urandom_range(0, 2))
          0:       key_save = pick_key();
          1:       key_load = pick_key();
          default: key_menu = pick_key();
        endcase
      end
    end

    repeat (4) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
